// File: rtl/arb_grant_hold_if.sv
`default_nettype none
// ============================================================================
//  Module   : arb_grant_hold_if
//  Brief    : Requester, arbiter and downstream signal bundle for arb_grant_hold.
//  Revision : 1.0  initial release
// ============================================================================
interface arb_grant_hold_if #(
    parameter int N_REQ  = 2,
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_write;
    logic [N_REQ*W_ADDR-1:0] req_addr;
    logic [N_REQ*W_DATA-1:0] req_wdata;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        resp_valid;
    logic [W_DATA-1:0]       resp_rdata;
    logic [N_REQ-1:0]        arb_req;
    logic [N_REQ-1:0]        arb_gnt;
    logic                    arb_canchange;
    logic                    m_valid;
    logic                    m_write;
    logic [W_ADDR-1:0]       m_addr;
    logic [W_DATA-1:0]       m_wdata;
    logic                    m_ready;
    logic                    m_rvalid;
    logic [W_DATA-1:0]       m_rdata;

    // The holding stage itself.
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, arb_gnt,
               m_ready, m_rvalid, m_rdata,
        output req_ready, resp_valid, resp_rdata, arb_req, arb_canchange,
               m_valid, m_write, m_addr, m_wdata
    );

    // Requesters, arbiter and downstream target seen together.
    modport master (
        output req_valid, req_write, req_addr, req_wdata, arb_gnt,
               m_ready, m_rvalid, m_rdata,
        input  req_ready, resp_valid, resp_rdata, arb_req, arb_canchange,
               m_valid, m_write, m_addr, m_wdata
    );
endinterface
`default_nettype wire

// File: rtl/arb_grant_hold.sv
`default_nettype none
// ============================================================================
//  Module   : arb_grant_hold
//  Brief    : Latches the arbiter grant for one request/response transaction,
//             muxes the owner onto the downstream port and routes the response.
//             Optional burst limit: define ARB_GRANT_HOLD_BURST_LIMIT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module arb_grant_hold #(
    parameter int N_REQ     = 2,
    parameter int W_ADDR    = 32,
    parameter int W_DATA    = 32,
    parameter int MAX_BURST = 8
) (
    input wire              clk,
    input wire              rst_n,
    arb_grant_hold_if.slave bus
);

    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_max_burst_range
        $error("MAX_BURST must lie in 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q;
    logic [N_REQ-1:0]    owner_q;
    logic [N_REQ-1:0]    resp_valid_q;
    logic                m_valid_q;
    logic                m_write_q;
    logic [W_ADDR-1:0]   m_addr_q;
    logic [W_DATA-1:0]   m_wdata_q;
    logic [W_DATA-1:0]   resp_rdata_q;

    logic                w_launch;
    logic                w_done;
    logic                w_canchange;
    logic                w_sel_write;
    logic [W_ADDR-1:0]   w_sel_addr;
    logic [W_DATA-1:0]   w_sel_wdata;

    assign w_launch = (state_q == ST_IDLE) && $onehot(bus.arb_gnt)
                      && (|(bus.arb_gnt & bus.req_valid));
    assign w_done   = (state_q == ST_RESP) && bus.m_rvalid;

    always_comb begin
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.arb_gnt[i]) begin
                w_sel_write = bus.req_write[i];
                w_sel_addr  = bus.req_addr[i*W_ADDR +: W_ADDR];
                w_sel_wdata = bus.req_wdata[i*W_DATA +: W_DATA];
            end
        end
    end

`ifdef ARB_GRANT_HOLD_BURST_LIMIT_EN
    localparam logic [7:0] c_MAX_BURST = 8'(MAX_BURST);

    logic [7:0]          burst_q;
    logic [7:0]          burst_d;
    logic [N_REQ-1:0]    last_owner_q;

    // Run length including the completion happening this cycle.
    assign burst_d     = (owner_q == last_owner_q) ? burst_q + 8'd1 : 8'd1;
    assign w_canchange = w_done && (burst_d == c_MAX_BURST);
`else
    assign w_canchange = w_done;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            m_valid_q    <= 1'b0;
            m_write_q    <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
`ifdef ARB_GRANT_HOLD_BURST_LIMIT_EN
            burst_q      <= 8'd0;
            last_owner_q <= '0;
`endif
        end else begin
            resp_valid_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (w_launch) begin
                        owner_q   <= bus.arb_gnt;
                        m_valid_q <= 1'b1;
                        m_write_q <= w_sel_write;
                        m_addr_q  <= w_sel_addr;
                        m_wdata_q <= w_sel_wdata;
                        state_q   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        state_q   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.m_rvalid) begin
                        resp_valid_q <= owner_q;
                        resp_rdata_q <= bus.m_rdata;
                        state_q      <= ST_IDLE;
`ifdef ARB_GRANT_HOLD_BURST_LIMIT_EN
                        last_owner_q <= owner_q;
                        burst_q      <= (burst_d == c_MAX_BURST) ? 8'd0 : burst_d;
`endif
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.arb_req       = bus.req_valid;
    assign bus.req_ready     = ((state_q == ST_REQ) && bus.m_ready) ? owner_q : '0;
    assign bus.arb_canchange = w_canchange;
    assign bus.m_valid       = m_valid_q;
    assign bus.m_write       = m_write_q;
    assign bus.m_addr        = m_addr_q;
    assign bus.m_wdata       = m_wdata_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_rdata    = resp_rdata_q;

endmodule
`default_nettype wire

// File: doc/arb_grant_hold.md
# arb_grant_hold

Transaction-holding stage downstream of the one-hot priority arbiter. It presents requester `valid` bits to the arbiter and consumes the arbiter's one-hot grant. It latches the grant as the owner for exactly one address/response transaction, muxes that owner's request onto the single downstream port, and routes the response back. It generates the arbiter's `canchange` pulse, which controls how often the arbiter's priority direction flips.

## Interface
- `N_REQ`, 2, number of requesters
- `W_ADDR`, 32, address width
- `W_DATA`, 32, data width
- `MAX_BURST`, 8, consecutive transactions one owner may win before a forced priority flip; valid range 1..255

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  N_REQ  per-requester request
- `req_write`  in  N_REQ  per-requester write flag
- `req_addr`  in  N_REQ*W_ADDR  packed addresses; requester i at `[i*W_ADDR +: W_ADDR]`
- `req_wdata`  in  N_REQ*W_DATA  packed write data
- `req_ready`  out  N_REQ  request accepted downstream; one-cycle pulse
- `resp_valid`  out  N_REQ  response strobe; one-cycle pulse
- `resp_rdata`  out  W_DATA  shared read data; valid only with `resp_valid`
- `arb_req`  out  N_REQ  equals `req_valid`; drives the arbiter input
- `arb_gnt`  in  N_REQ  one-hot grant from the arbiter; combinational from `arb_req`
- `arb_canchange`  out  1  priority-flip request to the arbiter
- `m_valid`, `m_write`  out  1  downstream request
- `m_addr`  out  W_ADDR  downstream address
- `m_wdata`  out  W_DATA  downstream write data
- `m_ready`  in  1  downstream accept
- `m_rvalid`  in  1  downstream response
- `m_rdata`  in  W_DATA  downstream read data

## Operation
- **FSM:** IDLE → REQ → RESP → IDLE.
- **IDLE:**
  - Sample `arb_gnt`.
  - If `arb_gnt` is one-hot and `arb_gnt & req_valid` is nonzero: register owner = `arb_gnt`, register the owner's write/addr/wdata into `m_*`, set `m_valid` to 1, and go to REQ.
  - Zero, multi-hot, or non-matching grant: stay in IDLE with no outputs. Multi-hot is illegal; the bench asserts on it.
- **REQ:**
  - `m_valid` is held with stable `m_*` until `m_ready`.
  - On `m_ready`: `req_ready[owner]` = 1 combinationally in that cycle, `m_valid` clears at the edge, go to RESP.
  - `m_rvalid` is ignored in REQ. Downstream must return the response at least 1 cycle after acceptance.
- **RESP:**
  - On `m_rvalid`: register `resp_rdata` = `m_rdata` and `resp_valid[owner]` = 1 for one cycle, go to IDLE.
  - The response is returned for writes too, with don't-care data.
- **Requester rules:**
  - A requester holds `req_valid` and its payload stable until its `req_ready`.
  - Deasserting `req_valid` after launch does not cancel the transaction.
- **`arb_canchange`:** combinational one-cycle pulse, only in RESP when `m_rvalid` = 1. The arbiter samples it on the same edge on which the FSM returns to IDLE.
- **Reset:** state IDLE, owner 0, `m_valid`/`m_write` 0, `m_addr`/`m_wdata` 0, `resp_valid` 0, `resp_rdata` 0, burst counter 0, last owner 0. Reset mid-transaction abandons the transaction: no `req_ready` or `resp_valid` pulse.

## Timing
- Cycle 0: IDLE with a valid grant.
- Cycle 1: `m_valid` = 1; if `m_ready` = 1, `req_ready` pulses in the same cycle.
- Cycle 2 earliest: `m_rvalid`.
- Cycle 3: `resp_valid` asserted and FSM in IDLE; a new grant can be sampled.
- Minimum 3 cycles per transaction; no pipelining, one outstanding transaction.
- `arb_gnt` is sampled only in IDLE; grant changes in REQ/RESP have no effect.

## Configuration
- Macro: `ARB_GRANT_HOLD_BURST_LIMIT_EN`.
- **Defined:**
  - An 8-bit burst counter counts consecutive completed transactions with owner == last owner; it resets to 1 on owner change.
  - `arb_canchange` pulses on the completion that makes the count reach `MAX_BURST`; the counter then clears to 0.
  - Completions from other owners reset the count.
- **Undefined:**
  - No counter is instantiated.
  - `arb_canchange` pulses on every completion.

## Test plan
- Single read, requester 0, `m_ready` = 1, `m_rvalid` 1 cycle later with `m_rdata` = 0xDEADBEEF → `m_valid` cycle 1, `req_ready` = 'b01 cycle 1, `resp_valid` = 'b01 with `resp_rdata` = 0xDEADBEEF cycle 3.
- Write with `m_ready` held low 4 cycles, addr 0x1000, wdata 0x55 → `m_valid`/`m_addr`/`m_wdata` stable all 4 cycles; exactly one `req_ready` pulse.
- Grant change during RESP (`arb_gnt` 'b01 → 'b10) → owner stays 0, response routed to `resp_valid[0]`.
- Both requesters continuously valid, macro defined, `MAX_BURST` = 3 → `arb_canchange` pulses only on the 3rd completion of the same owner; macro undefined → pulses on every completion.
- `rst_n` asserted in REQ with `m_valid` = 1 → `m_valid` = 0 immediately (asynchronously); after release, IDLE with no `resp_valid`.
- `arb_gnt` = 'b10 while `req_valid` = 'b01 → stays IDLE, `m_valid` remains 0.
